// File: rtl/eth_mdio_ctrl.sv
// eth_mdio_ctrl: clause-22 MDIO frame sequencer.
// One command at a time is latched, then serialised bit-by-bit on the
// MdcEn_n strobes of the MDC generator. Read data is captured from Mdi on
// the MdcEn strobes during the DATA phase.
module eth_mdio_ctrl #(
  parameter int PRE_LEN  = 32,  // preamble bits, 1..63
  parameter int GAP_BITS = 1    // idle bit-times after a frame, 1..7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        MdcEn,
  input  logic        MdcEn_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_nopre,
  input  logic [4:0]  cmd_phy,
  input  logic [4:0]  cmd_reg,
  input  logic [15:0] cmd_wdata,
  input  logic        Mdi,
  output logic        Mdo,
  output logic        MdoEn,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_HDR,
    S_TA,
    S_DATA,
    S_GAP
  } state_t;

  state_t      state, state_next;
  logic [5:0]  cnt, cnt_next;
  logic        mdo_next, mdoen_next, done_next;
  logic [3:0]  hdr_idx;

  // Latched command; pending marks an accepted command still waiting for
  // the first strobe, so the controller is already busy but still in IDLE.
  logic        pending;
  logic        lat_write, lat_nopre;
  logic [4:0]  lat_phy, lat_reg;
  logic [15:0] lat_wdata;
  logic [15:0] shift;
  logic [13:0] hdr;

  assign hdr       = {2'b01, (lat_write ? 2'b01 : 2'b10), lat_phy, lat_reg};
  assign cmd_ready = (state == S_IDLE) && !pending;
  assign busy      = !cmd_ready;

  // Next state, bit counter and the output bits of the bit-time being entered.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers latches.
    state_next = state;
    cnt_next   = cnt + 6'd1;
    done_next  = 1'b0;
    mdo_next   = 1'b0;
    mdoen_next = 1'b0;
    hdr_idx    = 4'd13 - cnt_next[3:0];

    case (state)
      S_IDLE: begin
        cnt_next = '0;
        if (pending) state_next = lat_nopre ? S_HDR : S_PRE;
      end
      S_PRE: if (cnt == 6'(PRE_LEN - 1)) begin
        state_next = S_HDR;
        cnt_next   = '0;
      end
      S_HDR: if (cnt == 6'd13) begin
        state_next = S_TA;
        cnt_next   = '0;
      end
      S_TA: if (cnt == 6'd1) begin
        state_next = S_DATA;
        cnt_next   = '0;
      end
      S_DATA: if (cnt == 6'd15) begin
        state_next = S_GAP;
        cnt_next   = '0;
        done_next  = 1'b1;
      end
      S_GAP: if (cnt == 6'(GAP_BITS - 1)) begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase

    hdr_idx = 4'd13 - cnt_next[3:0];
    case (state_next)
      S_PRE: begin
        mdo_next   = 1'b1;
        mdoen_next = 1'b1;
      end
      S_HDR: begin
        mdo_next   = hdr[hdr_idx];
        mdoen_next = 1'b1;
      end
      S_TA: begin
        // Write drives 1,0; read releases the line for the PHY.
        mdo_next   = lat_write && (cnt_next == 6'd0);
        mdoen_next = lat_write;
      end
      S_DATA: begin
        mdo_next   = lat_write && lat_wdata[~cnt_next[3:0]];
        mdoen_next = lat_write;
      end
      default: ;
    endcase
  end

  // Frame state and registered pad outputs, advanced only on MdcEn_n.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      Mdo   <= 1'b0;
      MdoEn <= 1'b0;
      done  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      done <= 1'b0;
      if (MdcEn_n) begin
        state <= state_next;
        cnt   <= cnt_next;
        Mdo   <= mdo_next;
        MdoEn <= mdoen_next;
        done  <= done_next;
      end
    end
  end

  // Command handshake: latch all fields, hold them until the next accept.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pending   <= 1'b0;
      lat_write <= 1'b0;
      lat_nopre <= 1'b0;
      lat_phy   <= '0;
      lat_reg   <= '0;
      lat_wdata <= '0;
    end else begin
      if (cmd_valid && cmd_ready) begin
        pending   <= 1'b1;
        lat_write <= cmd_write;
        lat_nopre <= cmd_nopre;
        lat_phy   <= cmd_phy;
        lat_reg   <= cmd_reg;
        lat_wdata <= cmd_wdata;
      end else if (MdcEn_n && state == S_IDLE) begin
        pending <= 1'b0;
      end
    end
  end

  // Read capture: shift Mdi on MdcEn (ignored when MdcEn_n also fires),
  // publish the word on the strobe that ends the last data bit.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shift   <= '0;
      rd_data <= '0;
    end else if (MdcEn_n) begin
      if (done_next && !lat_write) rd_data <= shift;
    end else if (MdcEn && state == S_DATA && !lat_write) begin
      shift <= {shift[14:0], Mdi};
    end
  end

endmodule

// File: tb/tb_eth_mdio_ctrl.sv
// Directed bench for eth_mdio_ctrl: builds each expected frame from the
// command fields, drives MdcEn/MdcEn_n strobes and compares captured sequences.
module tb_eth_mdio_ctrl;

  localparam int PRE_LEN  = 32;
  localparam int GAP_BITS = 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        MdcEn = 1'b0, MdcEn_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0, cmd_nopre = 1'b0;
  logic [4:0]  cmd_phy = '0, cmd_reg = '0;
  logic [15:0] cmd_wdata = '0;
  logic        Mdi = 1'b0;
  logic        cmd_ready, Mdo, MdoEn, busy, done;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;

  eth_mdio_ctrl #(.PRE_LEN(PRE_LEN), .GAP_BITS(GAP_BITS)) dut (
    .Clk(Clk), .Reset(Reset), .MdcEn(MdcEn), .MdcEn_n(MdcEn_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_nopre(cmd_nopre), .cmd_phy(cmd_phy), .cmd_reg(cmd_reg),
    .cmd_wdata(cmd_wdata), .Mdi(Mdi), .Mdo(Mdo), .MdoEn(MdoEn),
    .busy(busy), .done(done), .rd_data(rd_data)
  );

  always #5 Clk = ~Clk;

  // Count done-high cycles and handshakes mid-cycle, away from the edge.
  always @(negedge Clk) begin
    if (done === 1'b1) done_cnt++;
    if (cmd_valid && cmd_ready === 1'b1) hs_cnt++;
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // One bit-time: MdcEn pulse (sample point), then the MdcEn_n pulse.
  // With dual set, the MdcEn_n cycle also raises MdcEn with Mdi inverted.
  task automatic strobe(input int sp, input logic mdi_val, input logic dual);
    Mdi = mdi_val;
    MdcEn = 1'b1;
    cyc();
    MdcEn = 1'b0;
    repeat (sp - 1) cyc();
    if (dual) begin
      Mdi   = ~mdi_val;
      MdcEn = 1'b1;
    end
    MdcEn_n = 1'b1;
    cyc();
    MdcEn_n = 1'b0;
    MdcEn   = 1'b0;
  endtask

  task automatic accept(input logic wr, input logic nopre, input logic [4:0] phy,
                        input logic [4:0] rg, input logic [15:0] wd, input logic keep);
    cmd_write = wr; cmd_nopre = nopre; cmd_phy = phy; cmd_reg = rg; cmd_wdata = wd;
    cmd_valid = 1'b1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready got %b exp 1", cmd_ready);
    end
    cyc();
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_busy ready=%b busy=%b exp ready=0 busy=1", cmd_ready, busy);
    end
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Drive one whole frame plus its gap and compare against the model.
  task automatic run_frame(input string name, input logic wr, input logic nopre,
                           input logic [4:0] phy, input logic [4:0] rg,
                           input logic [15:0] wd, input logic [15:0] rdval,
                           input int sp, input int dual_at);
    logic [127:0] exp_mdo, exp_en, exp_done, got_mdo, got_en, got_done;
    logic [13:0]  hdr;
    logic [15:0]  got_rd;
    logic         mdi_val, gap_en_bad;
    int           pre, n, b, gaps, done0;
    pre = nopre ? 0 : PRE_LEN;
    n   = pre + 32;
    hdr = {2'b01, (wr ? 2'b01 : 2'b10), phy, rg};
    exp_mdo = '0; exp_en = '0; exp_done = '0;
    got_mdo = '0; got_en = '0; got_done = '0;
    for (int k = 0; k < pre; k++) begin
      exp_mdo[k] = 1'b1; exp_en[k] = 1'b1;
    end
    for (int k = 0; k < 14; k++) begin
      exp_mdo[pre + k] = hdr[13 - k]; exp_en[pre + k] = 1'b1;
    end
    exp_mdo[pre + 14] = wr; exp_en[pre + 14] = wr;
    exp_mdo[pre + 15] = 1'b0; exp_en[pre + 15] = wr;
    for (int k = 0; k < 16; k++) begin
      exp_mdo[pre + 16 + k] = wr & wd[15 - k]; exp_en[pre + 16 + k] = wr;
    end
    exp_done[n] = 1'b1;
    done0  = done_cnt;
    got_rd = '0;

    // Strobe s enters bit s; the MdcEn before it samples bit s-1.
    for (int s = 0; s <= n; s++) begin
      b = s - 1 - pre - 16;
      mdi_val = (b >= 0 && b < 16) ? rdval[15 - b] : 1'b0;
      strobe(sp, mdi_val, s == dual_at);
      got_mdo[s] = Mdo; got_en[s] = MdoEn; got_done[s] = done;
      if (s == n) got_rd = rd_data;
      repeat (sp - 1) cyc();
    end

    checks++;
    if (got_mdo !== exp_mdo) begin
      errors++;
      $display("FAIL %s mdo_seq got %h exp %h", name, got_mdo, exp_mdo);
    end
    checks++;
    if (got_en !== exp_en) begin
      errors++;
      $display("FAIL %s mdoen_seq got %h exp %h", name, got_en, exp_en);
    end
    checks++;
    if (got_done !== exp_done) begin
      errors++;
      $display("FAIL %s done_pos got %h exp %h", name, got_done, exp_done);
    end
    if (!wr) begin
      checks++;
      if (got_rd !== rdval) begin
        errors++;
        $display("FAIL %s rd_data got %h exp %h", name, got_rd, rdval);
      end
    end

    // Gap: count strobes until cmd_ready returns, MdoEn must stay low.
    gaps = 0;
    gap_en_bad = 1'b0;
    while (cmd_ready !== 1'b1 && gaps < GAP_BITS + 4) begin
      strobe(sp, 1'b0, 1'b0);
      if (MdoEn !== 1'b0 || Mdo !== 1'b0) gap_en_bad = 1'b1;
      gaps++;
      if (cmd_ready !== 1'b1) repeat (sp - 1) cyc();
    end
    checks++;
    if (gaps != GAP_BITS || gap_en_bad) begin
      errors++;
      $display("FAIL %s gap got %0d strobes (pad driven=%b) exp %0d", name, gaps, gap_en_bad, GAP_BITS);
    end
    checks++;
    if (done_cnt - done0 != 1) begin
      errors++;
      $display("FAIL %s done_cycles got %0d exp 1", name, done_cnt - done0);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (Mdo !== 1'b0 || MdoEn !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 ||
        done !== 1'b0 || rd_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset got mdo=%b en=%b rdy=%b busy=%b done=%b rd=%h exp 0 0 1 0 0 0000",
               Mdo, MdoEn, cmd_ready, busy, done, rd_data);
    end
    repeat (3) cyc();
    Reset = 1'b0;
    cyc();
  endtask

  task automatic test_write();
    accept(1'b1, 1'b0, 5'h01, 5'h00, 16'h1234, 1'b0);
    run_frame("write", 1'b1, 1'b0, 5'h01, 5'h00, 16'h1234, 16'h0000, 1, -1);
  endtask

  task automatic test_read();
    accept(1'b0, 1'b0, 5'h1F, 5'h02, 16'h0000, 1'b0);
    run_frame("read", 1'b0, 1'b0, 5'h1F, 5'h02, 16'h0000, 16'hABCD, 1, -1);
  endtask

  task automatic test_nopre();
    accept(1'b1, 1'b1, 5'h0A, 5'h15, 16'hBEEF, 1'b0);
    run_frame("nopre", 1'b1, 1'b1, 5'h0A, 5'h15, 16'hBEEF, 16'h0000, 1, -1);
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_cnt;
    accept(1'b1, 1'b0, 5'h03, 5'h04, 16'hA5A5, 1'b1);
    cmd_wdata = 16'h0F0F;
    run_frame("b2b_first", 1'b1, 1'b0, 5'h03, 5'h04, 16'hA5A5, 16'h0000, 1, -1);
    accept(1'b1, 1'b0, 5'h03, 5'h04, 16'h0F0F, 1'b0);
    run_frame("b2b_second", 1'b1, 1'b0, 5'h03, 5'h04, 16'h0F0F, 16'h0000, 1, -1);
    checks++;
    if (hs_cnt - hs0 != 2) begin
      errors++;
      $display("FAIL b2b_ready_cycles got %0d exp 2", hs_cnt - hs0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int done0;
    accept(1'b1, 1'b0, 5'h11, 5'h1E, 16'hFFFF, 1'b0);
    for (int s = 0; s <= PRE_LEN + 5; s++) strobe(1, 1'b0, 1'b0);
    done0 = done_cnt;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (MdoEn !== 1'b0 || Mdo !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset got en=%b mdo=%b rdy=%b busy=%b done=%b exp 0 0 1 0 0",
               MdoEn, Mdo, cmd_ready, busy, done);
    end
    #2 Reset = 1'b0;
    cyc();
    for (int s = 0; s < 40; s++) strobe(1, 1'b0, 1'b0);
    checks++;
    if (done_cnt != done0 || MdoEn !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_quiet got done=%0d en=%b rdy=%b exp 0 0 1",
               done_cnt - done0, MdoEn, cmd_ready);
    end
    accept(1'b0, 1'b0, 5'h07, 5'h09, 16'h0000, 1'b0);
    run_frame("after_reset_read", 1'b0, 1'b0, 5'h07, 5'h09, 16'h0000, 16'h8001, 1, -1);
  endtask

  task automatic test_pacing();
    // Same write as the first frame, strobes spaced 200 Clk apart.
    accept(1'b1, 1'b0, 5'h01, 5'h00, 16'h1234, 1'b0);
    run_frame("slow_write", 1'b1, 1'b0, 5'h01, 5'h00, 16'h1234, 16'h0000, 200, -1);
    // Dual strobe during a header bit: must still advance the frame.
    accept(1'b1, 1'b0, 5'h12, 5'h0C, 16'hC3C3, 1'b0);
    run_frame("dual_write", 1'b1, 1'b0, 5'h12, 5'h0C, 16'hC3C3, 16'h0000, 1, PRE_LEN + 6);
    // Dual strobe ending data bit 3 of a read, Mdi inverted then: no sample.
    accept(1'b0, 1'b0, 5'h05, 5'h1B, 16'h0000, 1'b0);
    run_frame("dual_read", 1'b0, 1'b0, 5'h05, 5'h1B, 16'h0000, 16'h5A3C, 1, PRE_LEN + 20);
  endtask

  initial begin
    #1;
    test_reset();
    test_write();
    test_read();
    test_nopre();
    test_back_to_back();
    test_reset_mid_frame();
    test_pacing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
